game_controller_pmod_emitter: RTL
=================================

Name: game_controller_pmod_emitter

Overview:
Transmit side of the gaming-PMOD serial link. Snapshots a BIT_WIDTH-bit button word and emits one serial frame on data/clk/latch lines: bits MSB first, then a latch pulse. Uses cases: loopback verification of game_controller_pmod_driver, and driving a second board's controller input from logic or a host bridge.

Parameters:
BIT_WIDTH, 12, bits per frame (SNES order: b,y,select,start,up,down,left,right,a,x,l,r; MSB = b).
HALF_PERIOD, 4, system clocks per pmod_clk half-period. Must be >= 3 so a 2-flop-synchronised receiver sees every edge.
FRAME_GAP, 64, idle clocks after each latch pulse before the next frame may start. Must be >= 1.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
buttons  in  BIT_WIDTH  button state, 1 = pressed. Sampled only at frame start.
enable  in  1  level; frames repeat while high.
pmod_data  out  1  serial data, registered.
pmod_clk  out  1  serial clock, registered; idles low.
pmod_latch  out  1  latch strobe, registered; idles low.
busy  out  1  high in every state except IDLE.
frame_done  out  1  one-cycle pulse on the cycle pmod_latch falls.

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; shift register, bit counter and timer 0.
- Receiver contract: the receiver shifts on pmod_clk falling edges and copies its shift register on the pmod_latch falling edge. Therefore:
  - pmod_data changes only together with a pmod_clk rise, or on entry to LATCH.
  - pmod_data is stable for HALF_PERIOD clocks before and after each pmod_clk fall.
- States:
  - IDLE: when enable = 1, load shreg <= buttons, bit_cnt <= 0, drive pmod_data <= buttons[MSB] and pmod_clk <= 1, go to SHIFT_HI. IDLE lasts 1 cycle when enable is already high.
  - SHIFT_HI: hold for HALF_PERIOD cycles, then pmod_clk <= 0 and go to SHIFT_LO.
  - SHIFT_LO: hold for HALF_PERIOD cycles. Then:
    - if bit_cnt == BIT_WIDTH-1: pmod_latch <= 1, pmod_data <= 0, go to LATCH;
    - else: shreg shifts left, bit_cnt++, pmod_data <= next bit, pmod_clk <= 1, go to SHIFT_HI.
  - LATCH: hold for 2*HALF_PERIOD cycles, then pmod_latch <= 0, frame_done pulses, go to GAP.
  - GAP: hold for FRAME_GAP cycles, then go to IDLE.
- Timer: single down-counter, width clog2(max(2*HALF_PERIOD, FRAME_GAP)+1), reloaded on each state entry.
- Frame period with enable held high: 1 + 2*HALF_PERIOD*BIT_WIDTH + 2*HALF_PERIOD + FRAME_GAP. With defaults: 1 + 96 + 8 + 64 = 169 clocks.
- Changes to buttons mid-frame are ignored; the snapshot is taken only in IDLE.
- enable deasserted mid-frame: the current frame completes, including GAP, then the block stays in IDLE.
- Reset mid-frame: outputs drop to 0 without a latch fall, so the receiver keeps its previous word. This is intended; no partial frame is ever latched.
- No combinational paths from inputs to outputs.

Decomposition:
- Shared package game_controller_pmod_pkg:
  - state enum {IDLE, SHIFT_HI, SHIFT_LO, LATCH, GAP};
  - SNES bit-index constants (B_IDX = 11 … R_IDX = 0);
  - default BIT_WIDTH = 12.
  - game_controller_pmod_decoder and this block both use it.
- No sub-module; the timer, shift register and FSM stay in one module. The bench instantiates game_controller_pmod_driver as the loopback receiver.

Test Plan:
- Reset values: assert reset with enable = 1 → all outputs 0 and busy = 0 while reset is held. Release → first pmod_clk rise 1 cycle later.
- Bit order: buttons = 12'hA5C, defaults → the values of pmod_data sampled at the 12 pmod_clk falling edges are 1,0,1,0,0,1,0,1,1,1,0,0. pmod_latch is high for exactly 8 cycles after the 12th fall. frame_done pulses once.
- Loopback: connect to game_controller_pmod_driver with rst_n = ~reset and buttons = 12'h801 (b and r pressed) → driver data_reg = 12'h801 within 3 clocks of the pmod_latch fall. Repeat with 12'hFFF and 12'h000.
- Back-to-back and snapshot: enable held, buttons changed from 12'h0F0 to 12'h00F at bit 5 of frame 1 → frame 1 delivers 12'h0F0 and frame 2 delivers 12'h00F. Rising edges of frame_done are exactly 169 clocks apart.
- Enable drop: deassert enable during bit 3 → the frame completes, GAP runs 64 cycles, then the block stays in IDLE with busy = 0 and no further pmod_clk edges.
- Reset mid-frame: assert reset during bit 7 → outputs are 0 in the same cycle. The receiver data_reg keeps its prior value, and after release the next frame transfers correctly.

Source files
------------

// File: rtl/game_controller_pmod_pkg.sv
// Shared definitions for the gaming-PMOD serial link: FSM states,
// SNES button bit positions and the default frame width.
package game_controller_pmod_pkg;

  localparam int DEFAULT_BIT_WIDTH = 12;

  // SNES controller bit positions within the frame word (MSB is sent first)
  localparam int B_IDX      = 11;
  localparam int Y_IDX      = 10;
  localparam int SELECT_IDX = 9;
  localparam int START_IDX  = 8;
  localparam int UP_IDX     = 7;
  localparam int DOWN_IDX   = 6;
  localparam int LEFT_IDX   = 5;
  localparam int RIGHT_IDX  = 4;
  localparam int A_IDX      = 3;
  localparam int X_IDX      = 2;
  localparam int L_IDX      = 1;
  localparam int R_IDX      = 0;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_HI,
    SHIFT_LO,
    LATCH,
    GAP
  } state_e;

  // Larger of two integers, used to size the shared down-counter
  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/game_controller_pmod_emitter.sv
// Transmit side of the gaming-PMOD link: snapshots the button word at frame
// start and shifts it out MSB first on pmod_data/pmod_clk, then strobes
// pmod_latch. All outputs are registered so the receiver never sees glitches.
module game_controller_pmod_emitter
  import game_controller_pmod_pkg::*;
#(
  parameter int BIT_WIDTH   = DEFAULT_BIT_WIDTH,
  parameter int HALF_PERIOD = 4,
  parameter int FRAME_GAP   = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BIT_WIDTH-1:0] buttons,
  input  logic                 enable,
  output logic                 pmod_data,
  output logic                 pmod_clk,
  output logic                 pmod_latch,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int TimerW = $clog2(maxInt(2 * HALF_PERIOD, FRAME_GAP) + 1);
  localparam int CntW   = $clog2(BIT_WIDTH + 1);

  // Reload values are one less than the hold length because the state is
  // left on the cycle the counter reads zero.
  localparam logic [TimerW-1:0] HalfLoad  = TimerW'(HALF_PERIOD - 1);
  localparam logic [TimerW-1:0] LatchLoad = TimerW'(2 * HALF_PERIOD - 1);
  localparam logic [TimerW-1:0] GapLoad   = TimerW'(FRAME_GAP - 1);
  localparam logic [CntW-1:0]   LastBit   = CntW'(BIT_WIDTH - 1);

  state_e               state_q, state_d;
  logic [TimerW-1:0]    timer_q, timer_d;
  logic [BIT_WIDTH-1:0] shiftReg_q, shiftReg_d;
  logic [CntW-1:0]      bitCnt_q, bitCnt_d;
  logic                 data_q, data_d;
  logic                 sclk_q, sclk_d;
  logic                 latch_q, latch_d;
  logic                 done_q, done_d;

  // State, datapath and output registers; reset drops every line immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      shiftReg_q <= '0;
      bitCnt_q   <= '0;
      data_q     <= 1'b0;
      sclk_q     <= 1'b0;
      latch_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      shiftReg_q <= shiftReg_d;
      bitCnt_q   <= bitCnt_d;
      data_q     <= data_d;
      sclk_q     <= sclk_d;
      latch_q    <= latch_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic: data only changes alongside a clock rise or on latch
  // entry, so it is stable a full half-period either side of every fall
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    shiftReg_d = shiftReg_q;
    bitCnt_d   = bitCnt_q;
    data_d     = data_q;
    sclk_d     = sclk_q;
    latch_d    = latch_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable) begin
          shiftReg_d = buttons;
          bitCnt_d   = '0;
          data_d     = buttons[BIT_WIDTH-1];
          sclk_d     = 1'b1;
          timer_d    = HalfLoad;
          state_d    = SHIFT_HI;
        end
      end

      SHIFT_HI: begin
        if (timer_q == '0) begin
          sclk_d  = 1'b0;
          timer_d = HalfLoad;
          state_d = SHIFT_LO;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      SHIFT_LO: begin
        if (timer_q == '0) begin
          if (bitCnt_q == LastBit) begin
            latch_d = 1'b1;
            data_d  = 1'b0;
            timer_d = LatchLoad;
            state_d = LATCH;
          end else begin
            shiftReg_d = shiftReg_q << 1;
            bitCnt_d   = bitCnt_q + 1'b1;
            data_d     = shiftReg_q[BIT_WIDTH-2];
            sclk_d     = 1'b1;
            timer_d    = HalfLoad;
            state_d    = SHIFT_HI;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      LATCH: begin
        if (timer_q == '0) begin
          latch_d = 1'b0;
          done_d  = 1'b1;
          timer_d = GapLoad;
          state_d = GAP;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      GAP: begin
        if (timer_q == '0) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign pmod_data  = data_q;
  assign pmod_clk   = sclk_q;
  assign pmod_latch = latch_q;
  assign frame_done = done_q;
  assign busy       = (state_q != IDLE);

endmodule
